// File: rtl/rx_bit_sequencer.sv
// Receive-path control FSM: times bit centres after a start edge, strobes data bits, checks stop bit.
// Optional even-parity bit between data and stop enabled by defining RX_PARITY_EN.
module rx_bit_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CNT_BITS     = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic serial_in,
  input  logic rx_abort,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic parity_error,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CHECK
  } state_t;

`ifdef RX_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
  localparam int unsigned BIT_LIMIT = DATA_BITS + 2;
`else
  localparam state_t AFTER_DATA = S_STOP;
  localparam int unsigned BIT_LIMIT = DATA_BITS + 1;
`endif

  localparam logic [CNT_BITS-1:0] ONE       = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CLK_TOP   = CNT_BITS'(CLKS_PER_BIT);
  localparam logic [CNT_BITS-1:0] HALF_M1   = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_BITS-1:0] LAST_DATA = CNT_BITS'(DATA_BITS - 1);
  localparam logic [CNT_BITS-1:0] BIT_MAX   = CNT_BITS'(BIT_LIMIT);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] clk_cnt_q, clk_cnt_d;
  logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic                fe_q, fe_d;
  logic                tick;
  logic [CNT_BITS-1:0] clk_inc;
`ifdef RX_PARITY_EN
  logic                par_q, par_d;
  logic                pe_q, pe_d;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      fe_q      <= 1'b0;
`ifdef RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      fe_q      <= fe_d;
`ifdef RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign tick    = (clk_cnt_q == CLK_TOP);
  assign clk_inc = tick ? ONE : clk_cnt_q + ONE;

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    fe_d         = fe_q;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
`ifdef RX_PARITY_EN
    par_d        = par_q;
    pe_d         = pe_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (start_bit_detected) begin
          state_d = S_START;
          fe_d    = 1'b0;
`ifdef RX_PARITY_EN
          par_d   = 1'b0;
          pe_d    = 1'b0;
`endif
        end
      end
      // One full period for the start bit, then half a period into data bit 0;
      // bit_cnt==1 marks the second pass. The counter is re-phased to 1 at the strobe.
      S_START: begin
        clk_cnt_d = clk_inc;
        if (tick) bit_cnt_d = bit_cnt_q + ONE;
        if (bit_cnt_q == ONE && clk_cnt_q == HALF_M1) begin
          shift_strobe = 1'b1;
          clk_cnt_d    = ONE;
`ifdef RX_PARITY_EN
          par_d        = par_q ^ serial_in;
`endif
          state_d      = (DATA_BITS == 1) ? AFTER_DATA : S_DATA;
        end
      end
      S_DATA: begin
        clk_cnt_d = clk_inc;
        if (tick) begin
          shift_strobe = 1'b1;
          bit_cnt_d    = bit_cnt_q + ONE;
`ifdef RX_PARITY_EN
          par_d        = par_q ^ serial_in;
`endif
          if (bit_cnt_q == LAST_DATA) state_d = AFTER_DATA;
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        clk_cnt_d = clk_inc;
        if (tick) begin
          bit_cnt_d = bit_cnt_q + ONE;
          par_d     = par_q ^ serial_in;
          state_d   = S_STOP;
        end
      end
`endif
      // Flags are registered at the stop sample so they are visible in CHECK.
      S_STOP: begin
        clk_cnt_d = clk_inc;
        if (tick) begin
          bit_cnt_d = bit_cnt_q + ONE;
          fe_d      = fe_q | ~serial_in;
`ifdef RX_PARITY_EN
          pe_d      = pe_q | par_q;
`endif
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
`ifdef RX_PARITY_EN
        load_buffer = ~fe_q & ~pe_q;
`else
        load_buffer = ~fe_q;
`endif
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    if (state_q != S_IDLE && (rx_abort || bit_cnt_q > BIT_MAX)) begin
      state_d      = S_IDLE;
      clk_cnt_d    = '0;
      bit_cnt_d    = '0;
      fe_d         = fe_q;
      shift_strobe = 1'b0;
      load_buffer  = 1'b0;
`ifdef RX_PARITY_EN
      par_d        = par_q;
      pe_d         = pe_q;
`endif
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign framing_error = fe_q;
`ifdef RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bit_sequencer.sv
// Scoreboard bench for rx_bit_sequencer: expected strobe/load events are queued by the
// stimulus thread and matched by a monitor; flag checks are directed at fixed cycles.
module tb_rx_bit_sequencer;

  localparam int unsigned C = 10;
  localparam int unsigned D = 8;
`ifdef RX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  // start pulse to load_buffer: 96 cycles, plus one bit period with parity
  localparam int unsigned LD = 96 + PB * C;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_bit_detected = 1'b0;
  logic serial_in = 1'b1;
  logic rx_abort = 1'b0;
  logic shift_strobe, load_buffer, framing_error, parity_error, busy;

  rx_bit_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(D), .CNT_BITS(4)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .start_bit_detected (start_bit_detected),
    .serial_in          (serial_in),
    .rx_abort           (rx_abort),
    .shift_strobe       (shift_strobe),
    .load_buffer        (load_buffer),
    .framing_error      (framing_error),
    .parity_error       (parity_error),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          kind;  // 0 = shift_strobe, 1 = load_buffer
    logic        val;
  } ev_t;

  ev_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned frame_id = 0;

  task automatic goto(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic got_event(input bit kind, input logic val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got event at cycle %0d expected none",
               kind ? "load" : "strobe", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || (kind == 1'b0 && e.val !== val)) begin
        n_bad++;
        $display("FAIL event: got kind=%0d cycle=%0d line=%b expected kind=%0d cycle=%0d line=%b",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (shift_strobe === 1'b1) got_event(1'b0, serial_in);
      if (load_buffer === 1'b1) got_event(1'b1, 1'b0);
    end
  end

  task automatic drive_frame(input int unsigned t0, input logic [7:0] data,
                             input logic par_bit, input logic stop_bit,
                             input int unsigned id);
    logic v;
    for (int k = 0; k <= int'(D + PB + 2); k++) begin
      goto(t0 + C * k);
      if (frame_id != id) return;
      if (k == 0) v = 1'b0;
      else if (k <= int'(D)) v = data[k-1];
      else if (PB == 1 && k == int'(D) + 1) v = par_bit;
      else if (k == int'(D + 1 + PB)) v = stop_bit;
      else v = 1'b1;
      serial_in = v;
    end
  endtask

  task automatic start_frame(input int unsigned t0, input logic [7:0] data,
                             input logic par_bit, input logic stop_bit,
                             input int unsigned nstr, input bit exp_load);
    ev_t e;
    int unsigned id;
    frame_id++;
    id = frame_id;
    for (int unsigned i = 0; i < nstr; i++) begin
      e.cyc = t0 + 15 + C * i;
      e.kind = 1'b0;
      e.val = data[i];
      exp_q.push_back(e);
    end
    if (exp_load) begin
      e.cyc = t0 + LD;
      e.kind = 1'b1;
      e.val = 1'b0;
      exp_q.push_back(e);
    end
    fork
      drive_frame(t0, data, par_bit, stop_bit, id);
    join_none
    goto(t0);
    start_bit_detected = 1'b1;
    goto(t0 + 1);
    start_bit_detected = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t;

    // reset state
    goto(1); #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobe", shift_strobe, 1'b0);
    chk("rst_load", load_buffer, 1'b0);
    chk("rst_ferr", framing_error, 1'b0);
    chk("rst_perr", parity_error, 1'b0);
    goto(3);
    n_rst = 1'b1;

    // good frame 0xA5
    t = 10;
    goto(t); #2;
    chk("s1_busy_t0", busy, 1'b0);
    start_frame(t, 8'hA5, ^8'hA5, 1'b1, 8, 1'b1);
    #2 chk("s1_busy_t1", busy, 1'b1);
    goto(t + LD); #2;
    chk("s1_busy_check", busy, 1'b1);
    chk("s1_ferr_check", framing_error, 1'b0);
    goto(t + LD + 1); #2;
    chk("s1_busy_after", busy, 1'b0);
    chk("s1_ferr_after", framing_error, 1'b0);

    // bad stop bit
    t = t + LD + 10;
    start_frame(t, 8'hA5, ^8'hA5, 1'b0, 8, 1'b0);
    goto(t + LD - 1); #2;
    chk("s2_ferr_before", framing_error, 1'b0);
    goto(t + LD); #2;
    chk("s2_ferr_set", framing_error, 1'b1);
    goto(t + LD + 15); #2;
    chk("s2_ferr_sticky", framing_error, 1'b1);
    chk("s2_busy_idle", busy, 1'b0);

    // spurious starts mid-frame and in CHECK
    t = t + LD + 20;
    goto(t); #2;
    chk("s3_ferr_at_accept", framing_error, 1'b1);
    start_frame(t, 8'hA5, ^8'hA5, 1'b1, 8, 1'b1);
    #2 chk("s3_ferr_cleared", framing_error, 1'b0);
    goto(t + 30);
    start_bit_detected = 1'b1;
    goto(t + 31);
    start_bit_detected = 1'b0;
    goto(t + LD);
    start_bit_detected = 1'b1;
    #2 chk("s3_busy_check", busy, 1'b1);
    goto(t + LD + 1);
    start_bit_detected = 1'b0;
    #2 chk("s3_busy_after", busy, 1'b0);
    goto(t + LD + 3); #2;
    chk("s3_no_restart", busy, 1'b0);

    // abort after third strobe, then restart
    t = t + LD + 10;
    start_frame(t, 8'h3C, ^8'h3C, 1'b1, 3, 1'b0);
    goto(t + 40);
    rx_abort = 1'b1;
    #2 chk("s4_busy_abort_cycle", busy, 1'b1);
    goto(t + 41);
    rx_abort = 1'b0;
    #2 chk("s4_busy_aborted", busy, 1'b0);
    chk("s4_ferr_kept", framing_error, 1'b0);
    t = t + 50;
    start_frame(t, 8'h5A, ^8'h5A, 1'b1, 8, 1'b1);
    goto(t + LD + 1); #2;
    chk("s4_busy_done", busy, 1'b0);

    // asynchronous reset mid-frame
    t = t + LD + 10;
    start_frame(t, 8'hFF, ^8'hFF, 1'b1, 4, 1'b0);
    goto(t + 50); #2;
    chk("s5_busy_pre", busy, 1'b1);
    frame_id++;
    n_rst = 1'b0;
    #1;
    chk("s5_busy_rst", busy, 1'b0);
    chk("s5_strobe_rst", shift_strobe, 1'b0);
    chk("s5_load_rst", load_buffer, 1'b0);
    goto(t + 52);
    n_rst = 1'b1;
    for (int unsigned i = 0; i < 30; i++) begin
      goto(t + 53 + i);
      serial_in = 1'($urandom_range(0, 1));
    end
    serial_in = 1'b1;
    #2 chk("s5_idle", busy, 1'b0);

`ifdef RX_PARITY_EN
    // parity: 0x03 has even parity 0
    t = t + 100;
    start_frame(t, 8'h03, 1'b1, 1'b1, 8, 1'b0);
    goto(t + LD - 1); #2;
    chk("s6_perr_before", parity_error, 1'b0);
    goto(t + LD); #2;
    chk("s6_perr_set", parity_error, 1'b1);
    chk("s6_ferr_clear", framing_error, 1'b0);
    t = t + LD + 10;
    start_frame(t, 8'h03, 1'b0, 1'b1, 8, 1'b1);
    #2 chk("s6_perr_cleared", parity_error, 1'b0);
    goto(t + LD); #2;
    chk("s6_perr_good", parity_error, 1'b0);
    t = t + LD;
`endif

    goto(t + 150);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d unmatched expected events, required 0 (next at cycle %0d)",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
